// File: rtl/nes_joypad_port_if.sv
// nes_joypad_port_if
// Bus bundle for the NES controller port block.
//   CPU side : ADDR, CPU_RW_n, CPU_DIN -> block; CPU_DOUT, CPU_DOUT_EN <- block
//   Pad side : PAD1_DATA, PAD2_DATA -> block; PAD_LATCH, PAD_CLK <- block
//   Debug    : BUTTONS_debug <- block ({pad2, pad1}, 1 = pressed)
// Modports: master = the CPU/pad environment, slave = nes_joypad_port.
interface nes_joypad_port_if;
    logic [15:0] ADDR;
    logic        CPU_RW_n;
    logic [7:0]  CPU_DIN;
    logic [7:0]  CPU_DOUT;
    logic        CPU_DOUT_EN;
    logic        PAD_LATCH;
    logic        PAD_CLK;
    logic        PAD1_DATA;
    logic        PAD2_DATA;
    logic [15:0] BUTTONS_debug;

    modport master (
        output ADDR, CPU_RW_n, CPU_DIN, PAD1_DATA, PAD2_DATA,
        input  CPU_DOUT, CPU_DOUT_EN, PAD_LATCH, PAD_CLK, BUTTONS_debug
    );

    modport slave (
        input  ADDR, CPU_RW_n, CPU_DIN, PAD1_DATA, PAD2_DATA,
        output CPU_DOUT, CPU_DOUT_EN, PAD_LATCH, PAD_CLK, BUTTONS_debug
    );
endinterface

// File: rtl/nes_joypad_port.sv
// nes_joypad_port
// CPU-side responder for the NES controller registers $4016/$4017 plus the
// pad-side poller that periodically deserialises physical pads over
// PAD_LATCH/PAD_CLK/PAD_DATA into button registers.
// Ports:
//   CPU_CLK   - sole clock, rising edge
//   CPU_RESET - asynchronous, active-high reset
//   bus       - nes_joypad_port_if.slave (CPU bus, pad lines, BUTTONS_debug)
// Parameters:
//   POLL_PERIOD - CPU_CLK cycles between poll starts (must exceed 17*HALF_BIT)
//   HALF_BIT    - CPU_CLK cycles per PAD_LATCH/PAD_CLK half-phase (>= 1)
// Configuration macro:
//   JOYPAD_P2_EN - when defined, builds the port-2 path served at $4017;
//                  otherwise $4017 is not claimed and BUTTONS_debug[15:8] = 0.
module nes_joypad_port #(
    parameter int unsigned POLL_PERIOD = 29830,
    parameter int unsigned HALF_BIT    = 6
) (
    input logic              CPU_CLK,
    input logic              CPU_RESET,
    nes_joypad_port_if.slave bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LATCH = 3'd1;
    localparam logic [2:0] ST_LOW   = 3'd2;
    localparam logic [2:0] ST_HIGH  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int unsigned PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int unsigned HW = $clog2(2 * HALF_BIT);

    localparam logic [PW-1:0] C_POLL_LAST  = PW'(POLL_PERIOD - 1);
    localparam logic [HW-1:0] C_LATCH_LAST = HW'(2 * HALF_BIT - 1);
    localparam logic [HW-1:0] C_HALF_LAST  = HW'(HALF_BIT - 1);

    logic [PW-1:0] r_poll_cnt;
    logic [2:0]    r_state;
    logic [HW-1:0] r_phase;
    logic [2:0]    r_bit;
    logic          r_strobe;
    logic [7:0]    r_sample1;
    logic [7:0]    r_btn1;
    logic [7:0]    r_shreg1;

    logic w_wr_4016;
    logic w_rd_4016;
    logic w_poll_start;

    assign w_wr_4016    = (bus.ADDR == 16'h4016) && !bus.CPU_RW_n;
    assign w_rd_4016    = (bus.ADDR == 16'h4016) &&  bus.CPU_RW_n;
    assign w_poll_start = (r_poll_cnt == C_POLL_LAST) && (r_state == ST_IDLE);

    // Free-running poll timebase, independent of CPU activity.
    always_ff @(posedge CPU_CLK or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            r_poll_cnt <= '0;
        end else if (r_poll_cnt == C_POLL_LAST) begin
            r_poll_cnt <= '0;
        end else begin
            r_poll_cnt <= r_poll_cnt + PW'(1);
        end
    end

`ifdef JOYPAD_P2_EN
    logic [7:0] r_sample2;
    logic [7:0] r_btn2;
    logic [7:0] r_shreg2;
    logic       w_rd_4017;
    logic       w_unused;

    assign w_rd_4017 = (bus.ADDR == 16'h4017) && bus.CPU_RW_n;
    assign w_unused  = ^bus.CPU_DIN[7:1];
`else
    logic w_unused;

    assign w_unused = ^{bus.CPU_DIN[7:1], bus.PAD2_DATA};
`endif

    // Pad poll sequencer. Samples collect in r_sampleN and are copied to the
    // button registers only in DONE, so a partial poll is never visible.
    always_ff @(posedge CPU_CLK or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            r_state   <= ST_IDLE;
            r_phase   <= '0;
            r_bit     <= '0;
            r_sample1 <= '0;
            r_btn1    <= '0;
`ifdef JOYPAD_P2_EN
            r_sample2 <= '0;
            r_btn2    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_poll_start) begin
                        r_state <= ST_LATCH;
                        r_phase <= '0;
                    end
                end
                ST_LATCH: begin
                    if (r_phase == C_LATCH_LAST) begin
                        r_state <= ST_LOW;
                        r_phase <= '0;
                        r_bit   <= '0;
                    end else begin
                        r_phase <= r_phase + HW'(1);
                    end
                end
                ST_LOW: begin
                    if (r_phase == C_HALF_LAST) begin
                        r_sample1[r_bit] <= ~bus.PAD1_DATA;
`ifdef JOYPAD_P2_EN
                        r_sample2[r_bit] <= ~bus.PAD2_DATA;
`endif
                        r_phase <= '0;
                        r_state <= (r_bit == 3'd7) ? ST_DONE : ST_HIGH;
                    end else begin
                        r_phase <= r_phase + HW'(1);
                    end
                end
                ST_HIGH: begin
                    if (r_phase == C_HALF_LAST) begin
                        r_state <= ST_LOW;
                        r_phase <= '0;
                        r_bit   <= r_bit + 3'd1;
                    end else begin
                        r_phase <= r_phase + HW'(1);
                    end
                end
                ST_DONE: begin
                    r_btn1  <= r_sample1;
`ifdef JOYPAD_P2_EN
                    r_btn2  <= r_sample2;
`endif
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobe and CPU-visible shift registers. Reload takes priority over
    // shifting; a reload in the DONE cycle still sees the old button value.
    always_ff @(posedge CPU_CLK or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            r_strobe <= 1'b0;
            r_shreg1 <= '0;
`ifdef JOYPAD_P2_EN
            r_shreg2 <= '0;
`endif
        end else begin
            if (w_wr_4016) begin
                r_strobe <= bus.CPU_DIN[0];
            end
            if (r_strobe) begin
                r_shreg1 <= r_btn1;
            end else if (w_rd_4016) begin
                r_shreg1 <= {1'b1, r_shreg1[7:1]};
            end
`ifdef JOYPAD_P2_EN
            if (r_strobe) begin
                r_shreg2 <= r_btn2;
            end else if (w_rd_4017) begin
                r_shreg2 <= {1'b1, r_shreg2[7:1]};
            end
`endif
        end
    end

    always_comb begin
        bus.CPU_DOUT    = '0;
        bus.CPU_DOUT_EN = 1'b0;
        if (w_rd_4016) begin
            bus.CPU_DOUT    = {7'b0100000, r_shreg1[0]};
            bus.CPU_DOUT_EN = 1'b1;
        end
`ifdef JOYPAD_P2_EN
        else if (w_rd_4017) begin
            bus.CPU_DOUT    = {7'b0100000, r_shreg2[0]};
            bus.CPU_DOUT_EN = 1'b1;
        end
`endif
    end

    assign bus.PAD_LATCH = (r_state == ST_LATCH);
    assign bus.PAD_CLK   = (r_state == ST_HIGH);

`ifdef JOYPAD_P2_EN
    assign bus.BUTTONS_debug = {r_btn2, r_btn1};
`else
    assign bus.BUTTONS_debug = {8'h00, r_btn1};
`endif

endmodule

// File: tb/tb_nes_joypad_port.sv
`timescale 1ns/1ps
module tb_nes_joypad_port;
    localparam int unsigned POLL_PERIOD = 64;
    localparam int unsigned HALF_BIT    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nes_joypad_port_if bus();

    nes_joypad_port #(
        .POLL_PERIOD(POLL_PERIOD),
        .HALF_BIT   (HALF_BIT)
    ) dut (
        .CPU_CLK  (clk),
        .CPU_RESET(rst),
        .bus      (bus)
    );

    // Behavioural 4021-style pads: parallel load while LATCH is high,
    // shift on PAD_CLK rising. Wire level is active-low.
    logic [7:0] pad1_word = 8'hFF;
    logic [7:0] pad2_word = 8'h7F;
    logic [7:0] sr1 = 8'hFF;
    logic [7:0] sr2 = 8'hFF;
    logic       pclk_q = 1'b0;

    always @(posedge clk) begin
        if (bus.PAD_LATCH) begin
            sr1 <= pad1_word;
            sr2 <= pad2_word;
        end else if (bus.PAD_CLK && !pclk_q) begin
            sr1 <= {1'b1, sr1[7:1]};
            sr2 <= {1'b1, sr2[7:1]};
        end
        pclk_q <= bus.PAD_CLK;
    end

    assign bus.PAD1_DATA = sr1[0];
    assign bus.PAD2_DATA = sr2[0];

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  din;
        logic [7:0]  dout;
        logic        en;
        string       tag;
    } vec_t;

    typedef struct {
        logic [7:0] dout;
        logic       en;
        string      tag;
    } exp_t;

    exp_t sb[$];

    function automatic vec_t mk(input logic [15:0] addr, input logic rw, input logic [7:0] din,
                                input logic [7:0] dout, input logic en, input string tag);
        vec_t v;
        v.addr = addr; v.rw = rw; v.din = din; v.dout = dout; v.en = en; v.tag = tag;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One CPU access: drive after the edge, expectation pushed to the
    // scoreboard, popped and compared at the following falling edge.
    task automatic bus_cycle(input vec_t v);
        exp_t e;
        @(posedge clk); #1;
        bus.ADDR     = v.addr;
        bus.CPU_RW_n = v.rw;
        bus.CPU_DIN  = v.din;
        e.dout = v.dout; e.en = v.en; e.tag = v.tag;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk({e.tag, " dout"}, {8'h00, bus.CPU_DOUT}, {8'h00, e.dout});
        chk({e.tag, " en"}, {15'h0, bus.CPU_DOUT_EN}, {15'h0, e.en});
    endtask

    task automatic run_tbl(input vec_t t[$]);
        foreach (t[i]) bus_cycle(t[i]);
    endtask

    task automatic bus_idle();
        @(posedge clk); #1;
        bus.ADDR     = 16'h0000;
        bus.CPU_RW_n = 1'b1;
        bus.CPU_DIN  = 8'h00;
    endtask

    task automatic wait_buttons(input logic [7:0] exp, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.BUTTONS_debug[7:0] == exp) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, " poll captured"}, {15'h0, seen}, 16'h0001);
    endtask

    // Cycles from a falling-edge reset release until PAD_LATCH is first seen.
    task automatic cycles_to_latch(output int k);
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (bus.PAD_LATCH) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    initial begin
        vec_t t2[$];
        vec_t t3[$];
        vec_t t6[$];
        int   first, lat, ck, k, rises;
        bit   seen;
        logic pclk_prev;

        t2.push_back(mk(16'h4016, 1'b0, 8'h01, 8'h00, 1'b0, "T2 wr strobe1"));
        t2.push_back(mk(16'h4016, 1'b0, 8'h00, 8'h00, 1'b0, "T2 wr strobe0"));
        t2.push_back(mk(16'h4016, 1'b1, 8'h00, 8'h41, 1'b1, "T2 rd1"));
        t2.push_back(mk(16'h4016, 1'b1, 8'h00, 8'h40, 1'b1, "T2 rd2"));
        t2.push_back(mk(16'h4016, 1'b1, 8'h00, 8'h40, 1'b1, "T2 rd3"));
        t2.push_back(mk(16'h4017, 1'b0, 8'h01, 8'h00, 1'b0, "T2 wr 4017"));
        t2.push_back(mk(16'h4015, 1'b1, 8'h00, 8'h00, 1'b0, "T2 rd 4015"));
        t2.push_back(mk(16'hC016, 1'b1, 8'h00, 8'h00, 1'b0, "T2 rd C016"));
        t2.push_back(mk(16'h4016, 1'b1, 8'h00, 8'h41, 1'b1, "T2 rd4"));
        t2.push_back(mk(16'h4016, 1'b1, 8'h00, 8'h40, 1'b1, "T2 rd5"));
        t2.push_back(mk(16'h4016, 1'b1, 8'h00, 8'h40, 1'b1, "T2 rd6"));
        t2.push_back(mk(16'h4016, 1'b1, 8'h00, 8'h40, 1'b1, "T2 rd7"));
        t2.push_back(mk(16'h4016, 1'b1, 8'h00, 8'h40, 1'b1, "T2 rd8"));
        t2.push_back(mk(16'h4016, 1'b1, 8'h00, 8'h41, 1'b1, "T2 rd9"));
        t2.push_back(mk(16'h4016, 1'b1, 8'h00, 8'h41, 1'b1, "T2 rd10"));

        t3.push_back(mk(16'h4016, 1'b0, 8'h01, 8'h00, 1'b0, "T3 wr strobe1"));
        t3.push_back(mk(16'h4016, 1'b1, 8'h00, 8'h41, 1'b1, "T3 rd1"));
        t3.push_back(mk(16'h4016, 1'b1, 8'h00, 8'h41, 1'b1, "T3 rd2"));
        t3.push_back(mk(16'h4016, 1'b1, 8'h00, 8'h41, 1'b1, "T3 rd3"));

`ifdef JOYPAD_P2_EN
        t6.push_back(mk(16'h4016, 1'b0, 8'h01, 8'h00, 1'b0, "T6 wr strobe1"));
        t6.push_back(mk(16'h4016, 1'b0, 8'h00, 8'h00, 1'b0, "T6 wr strobe0"));
        for (int i = 1; i <= 7; i++)
            t6.push_back(mk(16'h4017, 1'b1, 8'h00, 8'h40, 1'b1, $sformatf("T6 p2 rd%0d", i)));
        t6.push_back(mk(16'h4017, 1'b1, 8'h00, 8'h41, 1'b1, "T6 p2 rd8"));
        t6.push_back(mk(16'h4017, 1'b1, 8'h00, 8'h41, 1'b1, "T6 p2 rd9"));
`else
        t6.push_back(mk(16'h4017, 1'b1, 8'h00, 8'h00, 1'b0, "T6 p2off rd1"));
        t6.push_back(mk(16'h4017, 1'b1, 8'h00, 8'h00, 1'b0, "T6 p2off rd2"));
`endif

        // Reset state, with a live $4016 read on the bus.
        bus.ADDR     = 16'h4016;
        bus.CPU_RW_n = 1'b1;
        bus.CPU_DIN  = 8'h00;
        #2;
        chk("RST dout", {8'h00, bus.CPU_DOUT}, 16'h0040);
        chk("RST en", {15'h0, bus.CPU_DOUT_EN}, 16'h0001);
        chk("RST buttons", bus.BUTTONS_debug, 16'h0000);
        chk("RST latch", {15'h0, bus.PAD_LATCH}, 16'h0000);
        chk("RST padclk", {15'h0, bus.PAD_CLK}, 16'h0000);
        bus.ADDR = 16'h0000;

        // Test 1: first poll with A+Start pressed.
        pad1_word = 8'b11110110;
        @(negedge clk);
        rst = 1'b0;
        first = 0; lat = 0; ck = 0; seen = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (bus.PAD_LATCH) begin
                if (first == 0) first = i;
                lat++;
            end
            if (bus.PAD_CLK) ck++;
            if (bus.BUTTONS_debug[7:0] == 8'h09) begin
                seen = 1'b1;
                break;
            end
        end
        chk("T1 buttons seen", {15'h0, seen}, 16'h0001);
        chk("T1 first poll cycle", 16'(first), 16'(POLL_PERIOD));
        chk("T1 latch cycles", 16'(lat), 16'(2 * HALF_BIT));
        chk("T1 padclk high cycles", 16'(ck), 16'(7 * HALF_BIT));
        chk("T1 buttons", bus.BUTTONS_debug[7:0], 16'h0009);

        // Test 2: strobe pulse then serial reads, with foreign accesses mixed in.
        run_tbl(t2);
        bus_idle();

        // Test 3: strobe held high keeps returning button A.
        pad1_word = 8'hFE;
        wait_buttons(8'h01, "T3");
        run_tbl(t3);
        bus_idle();

        // Test 4: poll DONE while strobe=1, buttons 00 -> 80.
        pad1_word = 8'hFF;
        wait_buttons(8'h00, "T4 clear");
        pad1_word = 8'h7F;
        bus_cycle(mk(16'h4016, 1'b0, 8'h01, 8'h00, 1'b0, "T4 wr strobe1"));
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bus_cycle(mk(16'h4016, 1'b1, 8'h00, 8'h40, 1'b1, "T4 strobe rd"));
            if (bus.BUTTONS_debug[7:0] == 8'h80) begin
                seen = 1'b1;
                break;
            end
        end
        chk("T4 done seen", {15'h0, seen}, 16'h0001);
        bus_cycle(mk(16'h4016, 1'b0, 8'h00, 8'h00, 1'b0, "T4 wr strobe0"));
        for (int i = 1; i <= 7; i++)
            bus_cycle(mk(16'h4016, 1'b1, 8'h00, 8'h40, 1'b1, $sformatf("T4 rd%0d", i)));
        bus_cycle(mk(16'h4016, 1'b1, 8'h00, 8'h41, 1'b1, "T4 rd8"));
        bus_idle();

        // Test 6: port 2 (pad2 wire 7F = Right pressed on every poll so far).
        run_tbl(t6);
        bus_idle();
`ifdef JOYPAD_P2_EN
        chk("T6 buttons p2", {8'h00, bus.BUTTONS_debug[15:8]}, 16'h0080);
`else
        chk("T6 buttons p2 off", {8'h00, bus.BUTTONS_debug[15:8]}, 16'h0000);
`endif

        // Test 5: reset during the HIGH phase of bit 3.
        cycles_to_latch(k);
        chk("T5 poll started", {15'h0, (k != 0)}, 16'h0001);
        rises = 0;
        pclk_prev = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.PAD_CLK && !pclk_prev) rises++;
            pclk_prev = bus.PAD_CLK;
            if (rises == 4) break;
        end
        chk("T5 reached bit3 high", 16'(rises), 16'd4);
        chk("T5 padclk before rst", {15'h0, bus.PAD_CLK}, 16'h0001);
        rst = 1'b1;
        #1;
        chk("T5 padclk", {15'h0, bus.PAD_CLK}, 16'h0000);
        chk("T5 latch", {15'h0, bus.PAD_LATCH}, 16'h0000);
        chk("T5 buttons", bus.BUTTONS_debug, 16'h0000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cycles_to_latch(k);
        chk("T5 next poll cycle", 16'(k), 16'(POLL_PERIOD));
        wait_buttons(8'h80, "T5 recapture");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
